regfile_mp: RTL and testbench

- Parametrised multi-port register file: DEPTH x DATA_W storage, one write port, NUM_RD independent read ports.
- Each read port is a registered 1-of-DEPTH select with an optional same-cycle write bypass.
- Replaces the fixed 32x32 single-select read path in the regfile; sits between decode (addresses) and execute (operands).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_rd_port.sv | 74 +++++++
 rtl/regfile_mp.sv | 64 ++++++
 tb/tb_regfile_mp.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Decoder is sized for the widest supported address; callers slice the low DEPTH bits.
  localparam int DEC_ADDR_W = 8;
  localparam int DEC_DEPTH  = 2 ** DEC_ADDR_W;

  function automatic logic [DEC_DEPTH-1:0] onehot_decode(input logic [DEC_ADDR_W-1:0] addr);
    return DEC_DEPTH'(1) << addr;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [(2**ADDR_W)*DATA_W-1:0]  mem_i,
  input  logic                           rd_en_i,
  input  logic [ADDR_W-1:0]              rd_addr_i,
  input  logic                           wr_en_i,
  input  logic [ADDR_W-1:0]              wr_addr_i,
  input  logic [DATA_W-1:0]              wr_data_i,
  output logic [DATA_W-1:0]              rd_data_o,
  output logic                           rd_valid_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEC_DEPTH-1:0] dec_full;
  logic [DEPTH-1:0]     sel;
  logic                 unused_dec;
  logic [DATA_W-1:0]    mux_val;
  logic                 zero_hit;
  logic                 byp_hit;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;

  assign dec_full   = onehot_decode(DEC_ADDR_W'(rd_addr_i));
  assign sel        = dec_full[DEPTH-1:0];
  assign unused_dec = ^dec_full;

  assign zero_hit = (ZERO_REG != 0) && (rd_addr_i == '0);
  assign byp_hit  = (BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_i);

  always_comb begin
    mux_val = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mux_val |= mem_i[i*DATA_W +: DATA_W] & {DATA_W{sel[i]}};
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (rd_en_i) begin
      rd_valid_d = 1'b1;
      if (zero_hit) begin
        rd_data_d = '0;
      end else if (byp_hit) begin
        rd_data_d = wr_data_i;
      end else begin
        rd_data_d = mux_val;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/regfile_mp.sv
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Storage kept as one flat vector so it can feed every read port directly.
  logic [DEPTH*DATA_W-1:0] mem_q, mem_d;
  logic                    wr_hit;

  assign wr_hit = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_comb begin
    mem_d = mem_q;
    if (wr_hit) begin
      mem_d[wr_addr*DATA_W +: DATA_W] = wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .clk_i      (clock),
      .rst_i      (ctrl_reset),
      .mem_i      (mem_q),
      .rd_en_i    (rd_en[p]),
      .rd_addr_i  (rd_addr[p*ADDR_W +: ADDR_W]),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .rd_data_o  (rd_data[p*DATA_W +: DATA_W]),
      .rd_valid_o (rd_valid[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic        clock;
  logic        ctrl_reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_valid_a, rd_valid_b;

  int checks = 0;
  int errors = 0;

  // a: ZERO_REG=1, BYPASS=1 ; b: ZERO_REG=0, BYPASS=0
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clock(clock), .ctrl_reset(ctrl_reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clock(clock), .ctrl_reset(ctrl_reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: register contents and expected outputs per configuration.
  logic [31:0] m_mem   [2][32];
  logic [31:0] m_data  [2][2];
  logic        m_valid [2][2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock edge: predict outputs from the current inputs, then compare.
  task automatic cycle(input string tag);
    bit zero, byp;
    logic [4:0] ra;
    for (int c = 0; c < 2; c++) begin
      zero = (c == 0);
      byp  = (c == 0);
      for (int p = 0; p < 2; p++) begin
        ra = rd_addr[p*5 +: 5];
        if (ctrl_reset) begin
          m_valid[c][p] = 1'b0;
          m_data[c][p]  = 32'h0;
        end else if (rd_en[p]) begin
          m_valid[c][p] = 1'b1;
          if (zero && ra == 5'd0)                     m_data[c][p] = 32'h0;
          else if (byp && wr_en && wr_addr == ra)     m_data[c][p] = wr_data;
          else                                        m_data[c][p] = m_mem[c][ra];
        end else begin
          m_valid[c][p] = 1'b0;
        end
      end
      if (ctrl_reset) begin
        for (int r = 0; r < 32; r++) m_mem[c][r] = 32'h0;
      end else if (wr_en && !(zero && wr_addr == 5'd0)) begin
        m_mem[c][wr_addr] = wr_data;
      end
    end
    @(posedge clock);
    #1;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("%s model valid_a[%0d]", tag, p), 32'(rd_valid_a[p]), 32'(m_valid[0][p]));
      chk($sformatf("%s model data_a[%0d]", tag, p), rd_data_a[p*32 +: 32], m_data[0][p]);
      chk($sformatf("%s model valid_b[%0d]", tag, p), 32'(rd_valid_b[p]), 32'(m_valid[1][p]));
      chk($sformatf("%s model data_b[%0d]", tag, p), rd_data_b[p*32 +: 32], m_data[1][p]);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [1:0]  ev;
    logic [31:0] a0, a1, b0, b1;
  } vec_t;

  vec_t tbl[18];

  initial begin
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 32; r++) m_mem[c][r] = 32'h0;
      for (int p = 0; p < 2; p++) begin
        m_data[c][p]  = 32'h0;
        m_valid[c][p] = 1'b0;
      end
    end
    ctrl_reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;

    //            rst we  wa     wd            re     ra0    ra1    ev     a0            a1            b0            b1
    tbl[0]  = '{1'b1, 1'b1, 5'd7,  32'h00000055, 2'b11, 5'd7,  5'd7,  2'b00, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[1]  = '{1'b0, 1'b1, 5'd7,  32'hDEADBEEF, 2'b00, 5'd0,  5'd0,  2'b00, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        2'b01, 5'd7,  5'd0,  2'b01, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 5'd0,  32'h12345678, 2'b00, 5'd0,  5'd0,  2'b00, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 5'd0,  32'h0,        2'b11, 5'd0,  5'd0,  2'b11, 32'h0,        32'h0,        32'h12345678, 32'h12345678};
    tbl[5]  = '{1'b0, 1'b1, 5'd5,  32'h00000001, 2'b00, 5'd0,  5'd0,  2'b00, 32'h0,        32'h0,        32'h12345678, 32'h12345678};
    tbl[6]  = '{1'b0, 1'b1, 5'd5,  32'hA5A5A5A5, 2'b11, 5'd5,  5'd5,  2'b11, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000001, 32'h00000001};
    tbl[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,        2'b11, 5'd5,  5'd5,  2'b11, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[8]  = '{1'b0, 1'b1, 5'd3,  32'hFFFF0000, 2'b00, 5'd0,  5'd0,  2'b00, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,        2'b01, 5'd3,  5'd3,  2'b01, 32'hFFFF0000, 32'hA5A5A5A5, 32'hFFFF0000, 32'hA5A5A5A5};
    tbl[10] = '{1'b1, 1'b1, 5'd9,  32'h00000077, 2'b11, 5'd3,  5'd3,  2'b00, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[11] = '{1'b0, 1'b0, 5'd0,  32'h0,        2'b11, 5'd3,  5'd9,  2'b11, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[12] = '{1'b0, 1'b1, 5'd10, 32'h0A0A0A0A, 2'b00, 5'd0,  5'd0,  2'b00, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[13] = '{1'b0, 1'b1, 5'd11, 32'h0B0B0B0B, 2'b11, 5'd10, 5'd10, 2'b11, 32'h0A0A0A0A, 32'h0A0A0A0A, 32'h0A0A0A0A, 32'h0A0A0A0A};
    tbl[14] = '{1'b0, 1'b0, 5'd0,  32'h0,        2'b01, 5'd11, 5'd11, 2'b01, 32'h0B0B0B0B, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0A0A0A0A};
    tbl[15] = '{1'b0, 1'b0, 5'd0,  32'h0,        2'b11, 5'd10, 5'd11, 2'b11, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0A0A0A0A, 32'h0B0B0B0B};
    tbl[16] = '{1'b0, 1'b1, 5'd0,  32'hCAFEF00D, 2'b00, 5'd0,  5'd0,  2'b00, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0A0A0A0A, 32'h0B0B0B0B};
    tbl[17] = '{1'b0, 1'b1, 5'd0,  32'h13579BDF, 2'b11, 5'd0,  5'd0,  2'b11, 32'h0,        32'h0,        32'hCAFEF00D, 32'hCAFEF00D};

    @(posedge clock);
    #1;

    // Directed table
    for (int i = 0; i < 18; i++) begin
      ctrl_reset = tbl[i].rst;
      wr_en      = tbl[i].we;
      wr_addr    = tbl[i].wa;
      wr_data    = tbl[i].wd;
      rd_en      = tbl[i].re;
      rd_addr    = {tbl[i].ra1, tbl[i].ra0};
      cycle($sformatf("row%0d", i));
      chk($sformatf("row%0d valid_a", i), 32'(rd_valid_a), 32'(tbl[i].ev));
      chk($sformatf("row%0d valid_b", i), 32'(rd_valid_b), 32'(tbl[i].ev));
      chk($sformatf("row%0d data_a0", i), rd_data_a[31:0],  tbl[i].a0);
      chk($sformatf("row%0d data_a1", i), rd_data_a[63:32], tbl[i].a1);
      chk($sformatf("row%0d data_b0", i), rd_data_b[31:0],  tbl[i].b0);
      chk($sformatf("row%0d data_b1", i), rd_data_b[63:32], tbl[i].b1);
    end

    // Fill every register, then sweep both ports in opposite directions
    ctrl_reset = 1'b0;
    rd_en      = 2'b00;
    for (int i = 0; i < 32; i++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(i);
      wr_data = 32'(i) * 32'h01010101;
      cycle($sformatf("fill%0d", i));
    end
    wr_en = 1'b0;
    rd_en = 2'b11;
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(31 - i), 5'(i)};
      cycle($sformatf("sweep%0d", i));
      chk($sformatf("sweep%0d a0", i), rd_data_a[31:0],  32'(i) * 32'h01010101);
      chk($sformatf("sweep%0d a1", i), rd_data_a[63:32], 32'(31 - i) * 32'h01010101);
      chk($sformatf("sweep%0d b0", i), rd_data_b[31:0],  32'(i) * 32'h01010101);
      chk($sformatf("sweep%0d b1", i), rd_data_b[63:32], 32'(31 - i) * 32'h01010101);
    end

    // Randomised traffic with collisions and occasional reset
    for (int n = 0; n < 300; n++) begin
      ctrl_reset = ($urandom_range(0, 39) == 0);
      wr_en      = 1'($urandom_range(0, 1));
      wr_addr    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wr_data    = $urandom;
      rd_en      = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        rd_addr[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      end
      cycle($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
